udp_port_switch: RTL and testbench
==================================

// Module: udp_port_switch
// PURPOSE
//  N-channel UDP port switch between udp_complete and user logic; generalises the single-port UDP loopback.
//  RX: each received UDP frame is steered to the channel whose port_table entry equals its dest port; unmatched frames are dropped and counted.
//  TX: round-robin arbitration of N channel frames onto the single udp_complete TX input; source port = channel's table entry.
// PARAMETERS
//  CHANNELS    4    number of user channels (1..16)
//  CNT_WIDTH   16   width of drop_count (saturating)
// PORTS
//  clk                         in   1         system clock
//  rst_n                       in   1         asynchronous reset, active low
//  port_table                  in   16*N      ch k port = [16k+15:16k]; 0 = channel disabled
//  s_udp_hdr_{valid,ready}     in/out 1/1     RX header from udp_complete
//  s_udp_{ip_source_ip,source_port,dest_port,length} in 32/16/16/16  RX header fields
//  s_udp_payload_axis_{tdata,tvalid,tready,tlast,tuser} in/in/out/in/in 8/1/1/1/1  RX payload
//  m_ch_hdr_valid / m_ch_hdr_ready   out/in N/N  per-channel RX header handshake
//  m_ch_{ip_source_ip,source_port,dest_port,length} out 32/16/16/16  shared registered RX header
//  m_ch_payload_{tdata,tlast,tuser} out 8/1/1 shared; m_ch_payload_{tvalid,tready} out/in N/N
//  s_ch_hdr_{valid,ready}      in/out N/N     per-channel TX header
//  s_ch_{ip_dest_ip,dest_port,length} in 32N/16N/16N  per-channel TX header fields
//  s_ch_payload_{tdata,tvalid,tready,tlast,tuser} in/in/out/in/in 8N/N/N/N/N
//  m_udp_hdr_{valid,ready}     out/in 1/1     TX header to udp_complete
//  m_udp_{ip_dest_ip,source_port,dest_port,length} out 32/16/16/16
//  m_udp_payload_axis_{tdata,tvalid,tready,tlast,tuser} out/out/in/out/out 8/1/1/1/1
//  drop_count                  out  CNT_WIDTH  unmatched RX frames, saturating
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, header regs 0, drop_count 0, RX FSM IDLE, TX FSM IDLE, rr pointer 0.
//  RX FSM: IDLE -> s_udp_hdr_ready=1; on hdr handshake register fields, lookup lowest k with port_table[k]!=0
//   and ==dest_port (sampled that cycle). Match -> HDR(k); none -> DROP.
//  HDR(k): m_ch_hdr_valid[k]=1 from next cycle until m_ch_hdr_ready[k]; then PAYLOAD(k).
//  PAYLOAD(k): combinational pass-through: m_ch_payload_tvalid[k]=s tvalid, s tready=m_ch_payload_tready[k];
//   other channels tvalid=0. Beat with tlast -> IDLE. tuser forwarded unchanged.
//  DROP: s tready=1; beat with tlast -> IDLE, drop_count+=1 (holds at all-ones).
//  RX header -> channel latency: 1 cycle. No new header accepted before tlast of current frame.
//  TX FSM: IDLE -> grant = first k with s_ch_hdr_valid[k], searching from rr pointer upward, wrapping mod N;
//   pulse s_ch_hdr_ready[k] 1 cycle, register ip_dest_ip/dest_port/length, source_port=port_table[k] -> HDR.
//  TX HDR: m_udp_hdr_valid=1 until m_udp_hdr_ready -> PAYLOAD(k).
//  TX PAYLOAD(k): pass-through of channel k payload; others tready=0; tlast beat -> IDLE, rr pointer=k+1 mod N.
//  Grant is frame-locked: no re-arbitration until tlast. Disabled channel (port 0) still arbitrated for TX.
//  RX and TX paths fully independent; both may be mid-frame simultaneously.
//  Payload abort is signalled only by tuser on the tlast beat; switch never truncates frames.
//  rst_n asserted mid-frame: immediate return to reset state; partial frames abandoned, no handshake outputs high.
//  port_table must be stable while a frame is in flight; change only affects the next lookup.
// TESTING
//  1 port_table={0,80,1234,7}; RX dest 1234, 10-byte payload -> hdr on ch1 1 cycle later, 10 beats on ch1 only.
//  2 RX dest 5555, 64 bytes -> s tready=1 throughout, no ch valid, drop_count 0->1; saturate at 16'hFFFF holds.
//  3 Duplicate ports ch0=ch2=80 -> frame to ch0 only; ch0 port 0 and dest 0 -> dropped.
//  4 TX ch0,ch2,ch3 valid together, rr=0 -> frame order 0,2,3,0; source_port = each channel's table entry.
//  5 m_udp_payload_axis_tready toggled 50% mid-frame -> byte sequence intact, no grant change until tlast.
//  6 rst_n low during RX PAYLOAD and TX HDR -> all valids 0 next edge; post-reset frame routes correctly.

Source files
------------

// File: rtl/udp_port_switch_if.sv
// Bus bundle for the N-channel UDP port switch.
// slave = switch side, master = environment side.
interface udp_port_switch_if #(
    parameter int CHANNELS = 4
);
    logic                    s_udp_hdr_valid;
    logic                    s_udp_hdr_ready;
    logic [31:0]             s_udp_ip_source_ip;
    logic [15:0]             s_udp_source_port;
    logic [15:0]             s_udp_dest_port;
    logic [15:0]             s_udp_length;
    logic [7:0]              s_udp_payload_axis_tdata;
    logic                    s_udp_payload_axis_tvalid;
    logic                    s_udp_payload_axis_tready;
    logic                    s_udp_payload_axis_tlast;
    logic                    s_udp_payload_axis_tuser;

    logic [CHANNELS-1:0]     m_ch_hdr_valid;
    logic [CHANNELS-1:0]     m_ch_hdr_ready;
    logic [31:0]             m_ch_ip_source_ip;
    logic [15:0]             m_ch_source_port;
    logic [15:0]             m_ch_dest_port;
    logic [15:0]             m_ch_length;
    logic [7:0]              m_ch_payload_tdata;
    logic                    m_ch_payload_tlast;
    logic                    m_ch_payload_tuser;
    logic [CHANNELS-1:0]     m_ch_payload_tvalid;
    logic [CHANNELS-1:0]     m_ch_payload_tready;

    logic [CHANNELS-1:0]     s_ch_hdr_valid;
    logic [CHANNELS-1:0]     s_ch_hdr_ready;
    logic [32*CHANNELS-1:0]  s_ch_ip_dest_ip;
    logic [16*CHANNELS-1:0]  s_ch_dest_port;
    logic [16*CHANNELS-1:0]  s_ch_length;
    logic [8*CHANNELS-1:0]   s_ch_payload_tdata;
    logic [CHANNELS-1:0]     s_ch_payload_tvalid;
    logic [CHANNELS-1:0]     s_ch_payload_tready;
    logic [CHANNELS-1:0]     s_ch_payload_tlast;
    logic [CHANNELS-1:0]     s_ch_payload_tuser;

    logic                    m_udp_hdr_valid;
    logic                    m_udp_hdr_ready;
    logic [31:0]             m_udp_ip_dest_ip;
    logic [15:0]             m_udp_source_port;
    logic [15:0]             m_udp_dest_port;
    logic [15:0]             m_udp_length;
    logic [7:0]              m_udp_payload_axis_tdata;
    logic                    m_udp_payload_axis_tvalid;
    logic                    m_udp_payload_axis_tready;
    logic                    m_udp_payload_axis_tlast;
    logic                    m_udp_payload_axis_tuser;

    modport slave (
        input  s_udp_hdr_valid, s_udp_ip_source_ip, s_udp_source_port,
        input  s_udp_dest_port, s_udp_length,
        input  s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid,
        input  s_udp_payload_axis_tlast, s_udp_payload_axis_tuser,
        output s_udp_hdr_ready, s_udp_payload_axis_tready,
        output m_ch_hdr_valid, m_ch_ip_source_ip, m_ch_source_port,
        output m_ch_dest_port, m_ch_length,
        output m_ch_payload_tdata, m_ch_payload_tlast, m_ch_payload_tuser,
        output m_ch_payload_tvalid,
        input  m_ch_hdr_ready, m_ch_payload_tready,
        input  s_ch_hdr_valid, s_ch_ip_dest_ip, s_ch_dest_port, s_ch_length,
        input  s_ch_payload_tdata, s_ch_payload_tvalid,
        input  s_ch_payload_tlast, s_ch_payload_tuser,
        output s_ch_hdr_ready, s_ch_payload_tready,
        output m_udp_hdr_valid, m_udp_ip_dest_ip, m_udp_source_port,
        output m_udp_dest_port, m_udp_length,
        output m_udp_payload_axis_tdata, m_udp_payload_axis_tvalid,
        output m_udp_payload_axis_tlast, m_udp_payload_axis_tuser,
        input  m_udp_hdr_ready, m_udp_payload_axis_tready
    );

    modport master (
        output s_udp_hdr_valid, s_udp_ip_source_ip, s_udp_source_port,
        output s_udp_dest_port, s_udp_length,
        output s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid,
        output s_udp_payload_axis_tlast, s_udp_payload_axis_tuser,
        input  s_udp_hdr_ready, s_udp_payload_axis_tready,
        input  m_ch_hdr_valid, m_ch_ip_source_ip, m_ch_source_port,
        input  m_ch_dest_port, m_ch_length,
        input  m_ch_payload_tdata, m_ch_payload_tlast, m_ch_payload_tuser,
        input  m_ch_payload_tvalid,
        output m_ch_hdr_ready, m_ch_payload_tready,
        output s_ch_hdr_valid, s_ch_ip_dest_ip, s_ch_dest_port, s_ch_length,
        output s_ch_payload_tdata, s_ch_payload_tvalid,
        output s_ch_payload_tlast, s_ch_payload_tuser,
        input  s_ch_hdr_ready, s_ch_payload_tready,
        input  m_udp_hdr_valid, m_udp_ip_dest_ip, m_udp_source_port,
        input  m_udp_dest_port, m_udp_length,
        input  m_udp_payload_axis_tdata, m_udp_payload_axis_tvalid,
        input  m_udp_payload_axis_tlast, m_udp_payload_axis_tuser,
        output m_udp_hdr_ready, m_udp_payload_axis_tready
    );
endinterface

// File: rtl/udp_port_switch.sv
// N-channel UDP port switch: RX steered by dest port lookup,
// TX round-robin merged with per-channel source port.
module udp_port_switch #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [16*CHANNELS-1:0] port_table,
    udp_port_switch_if.slave       bus,
    output logic [CNT_WIDTH-1:0]   drop_count
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        RX_IDLE, RX_HDR, RX_PAY, RX_DROP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE, TX_HDR, TX_PAY
    } tx_state_t;

    rx_state_t       rx_state_q, rx_state_d;
    tx_state_t       tx_state_q, tx_state_d;
    logic [CH_W-1:0] rx_ch_q;
    logic [CH_W-1:0] tx_ch_q;
    logic [CH_W-1:0] rr_q;
    logic            rx_hit;
    logic [CH_W-1:0] rx_hit_ch;
    logic            tx_any;
    logic [CH_W-1:0] tx_grant;
    logic            rx_beat;
    logic            tx_beat;

    function automatic logic [CH_W-1:0] wrap_add(
        input logic [CH_W-1:0] a,
        input int              b
    );
        int s;
        s = int'(a) + b;
        if (s >= CHANNELS) s = s - CHANNELS;
        return CH_W'(s);
    endfunction

    // Lowest enabled channel whose port equals the RX dest port.
    always_comb begin
        rx_hit    = 1'b0;
        rx_hit_ch = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (port_table[16*k +: 16] != 16'd0 &&
                port_table[16*k +: 16] == bus.s_udp_dest_port) begin
                rx_hit    = 1'b1;
                rx_hit_ch = CH_W'(k);
            end
        end
    end

    assign rx_beat = bus.s_udp_payload_axis_tvalid &&
                     bus.s_udp_payload_axis_tready;

    assign bus.m_ch_payload_tdata = bus.s_udp_payload_axis_tdata;
    assign bus.m_ch_payload_tlast = bus.s_udp_payload_axis_tlast;
    assign bus.m_ch_payload_tuser = bus.s_udp_payload_axis_tuser;

    // RX next state and per-channel handshake steering.
    always_comb begin
        rx_state_d                    = rx_state_q;
        bus.s_udp_hdr_ready           = 1'b0;
        bus.s_udp_payload_axis_tready = 1'b0;
        bus.m_ch_hdr_valid            = '0;
        bus.m_ch_payload_tvalid       = '0;
        unique case (rx_state_q)
            RX_IDLE: begin
                bus.s_udp_hdr_ready = rst_n;
                if (bus.s_udp_hdr_valid)
                    rx_state_d = rx_hit ? RX_HDR : RX_DROP;
            end
            RX_HDR: begin
                bus.m_ch_hdr_valid[rx_ch_q] = 1'b1;
                if (bus.m_ch_hdr_ready[rx_ch_q])
                    rx_state_d = RX_PAY;
            end
            RX_PAY: begin
                bus.m_ch_payload_tvalid[rx_ch_q] =
                    bus.s_udp_payload_axis_tvalid;
                bus.s_udp_payload_axis_tready =
                    bus.m_ch_payload_tready[rx_ch_q];
                if (rx_beat && bus.s_udp_payload_axis_tlast)
                    rx_state_d = RX_IDLE;
            end
            RX_DROP: begin
                bus.s_udp_payload_axis_tready = 1'b1;
                if (rx_beat && bus.s_udp_payload_axis_tlast)
                    rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state, captured header, target channel and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q            <= RX_IDLE;
            rx_ch_q               <= '0;
            bus.m_ch_ip_source_ip <= '0;
            bus.m_ch_source_port  <= '0;
            bus.m_ch_dest_port    <= '0;
            bus.m_ch_length       <= '0;
            drop_count            <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            if (rx_state_q == RX_IDLE && bus.s_udp_hdr_valid) begin
                rx_ch_q               <= rx_hit_ch;
                bus.m_ch_ip_source_ip <= bus.s_udp_ip_source_ip;
                bus.m_ch_source_port  <= bus.s_udp_source_port;
                bus.m_ch_dest_port    <= bus.s_udp_dest_port;
                bus.m_ch_length       <= bus.s_udp_length;
            end
            if (rx_state_q == RX_DROP && rx_beat &&
                bus.s_udp_payload_axis_tlast && drop_count != '1)
                drop_count <= drop_count + 1'b1;
        end
    end

    // First requesting channel at or after the rr pointer, wrapping.
    always_comb begin
        tx_any   = 1'b0;
        tx_grant = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.s_ch_hdr_valid[wrap_add(rr_q, i)]) begin
                tx_any   = 1'b1;
                tx_grant = wrap_add(rr_q, i);
            end
        end
    end

    assign tx_beat = bus.m_udp_payload_axis_tvalid &&
                     bus.m_udp_payload_axis_tready;

    assign bus.m_udp_payload_axis_tdata =
        bus.s_ch_payload_tdata[8*tx_ch_q +: 8];
    assign bus.m_udp_payload_axis_tlast = bus.s_ch_payload_tlast[tx_ch_q];
    assign bus.m_udp_payload_axis_tuser = bus.s_ch_payload_tuser[tx_ch_q];

    // TX next state; grant is held until the frame's last beat.
    always_comb begin
        tx_state_d                    = tx_state_q;
        bus.s_ch_hdr_ready            = '0;
        bus.s_ch_payload_tready       = '0;
        bus.m_udp_hdr_valid           = 1'b0;
        bus.m_udp_payload_axis_tvalid = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_any) begin
                    bus.s_ch_hdr_ready[tx_grant] = rst_n;
                    tx_state_d = TX_HDR;
                end
            end
            TX_HDR: begin
                bus.m_udp_hdr_valid = 1'b1;
                if (bus.m_udp_hdr_ready)
                    tx_state_d = TX_PAY;
            end
            TX_PAY: begin
                bus.m_udp_payload_axis_tvalid =
                    bus.s_ch_payload_tvalid[tx_ch_q];
                bus.s_ch_payload_tready[tx_ch_q] =
                    bus.m_udp_payload_axis_tready;
                if (tx_beat && bus.m_udp_payload_axis_tlast)
                    tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX state, granted channel, outgoing header and rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q            <= TX_IDLE;
            tx_ch_q               <= '0;
            rr_q                  <= '0;
            bus.m_udp_ip_dest_ip  <= '0;
            bus.m_udp_source_port <= '0;
            bus.m_udp_dest_port   <= '0;
            bus.m_udp_length      <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            if (tx_state_q == TX_IDLE && tx_any) begin
                tx_ch_q               <= tx_grant;
                bus.m_udp_ip_dest_ip  <= bus.s_ch_ip_dest_ip[32*tx_grant +: 32];
                bus.m_udp_dest_port   <= bus.s_ch_dest_port[16*tx_grant +: 16];
                bus.m_udp_length      <= bus.s_ch_length[16*tx_grant +: 16];
                bus.m_udp_source_port <= port_table[16*tx_grant +: 16];
            end
            if (tx_state_q == TX_PAY && tx_beat &&
                bus.m_udp_payload_axis_tlast)
                rr_q <= wrap_add(tx_ch_q, 1);
        end
    end
endmodule

// File: tb/tb_udp_port_switch.sv
// Directed bench for udp_port_switch: RX steering, drops,
// TX round-robin, backpressure and mid-frame reset.
module tb_udp_port_switch;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [63:0] port_table;
    logic [3:0] drop_count;
    int         checks = 0;
    int         errors = 0;

    udp_port_switch_if #(.CHANNELS(4)) bus ();

    udp_port_switch #(
        .CHANNELS  (4),
        .CNT_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_table (port_table),
        .bus        (bus),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_hdr(input logic [15:0] dport);
        bus.s_udp_hdr_valid    = 1'b1;
        bus.s_udp_dest_port    = dport;
        bus.s_udp_ip_source_ip = 32'h0A00_0001;
        bus.s_udp_source_port  = 16'd5000;
        bus.s_udp_length       = 16'd18;
        #1;
        check("rx_hdr_ready", bus.s_udp_hdr_ready, 1);
        step();
        bus.s_udp_hdr_valid = 1'b0;
    endtask

    task automatic rx_deliver(input logic [3:0] mask,
                              input logic [15:0] dport);
        #1;
        check("rx_ch_hdr_valid", bus.m_ch_hdr_valid, mask);
        check("rx_ch_dest_port", bus.m_ch_dest_port, dport);
        check("rx_ch_src_ip", bus.m_ch_ip_source_ip, 32'h0A00_0001);
        bus.m_ch_hdr_ready = 4'hF;
        step();
        bus.m_ch_hdr_ready = 4'h0;
        check("rx_ch_hdr_done", bus.m_ch_hdr_valid, 0);
    endtask

    task automatic rx_pay(input int n, input logic [3:0] vmask,
                          input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            bus.s_udp_payload_axis_tdata  = base + 8'(i);
            bus.s_udp_payload_axis_tvalid = 1'b1;
            bus.s_udp_payload_axis_tlast  = (i == n - 1);
            bus.s_udp_payload_axis_tuser  = (i == n - 1);
            #1;
            check("rx_pay_valid", bus.m_ch_payload_tvalid, vmask);
            check("rx_pay_ready", bus.s_udp_payload_axis_tready, 1);
            if (vmask != 4'h0) begin
                check("rx_pay_data", bus.m_ch_payload_tdata, base + 8'(i));
                check("rx_pay_tuser", bus.m_ch_payload_tuser, (i == n - 1));
            end
            step();
        end
        bus.s_udp_payload_axis_tvalid = 1'b0;
        bus.s_udp_payload_axis_tlast  = 1'b0;
        bus.s_udp_payload_axis_tuser  = 1'b0;
    endtask

    task automatic tx_drive(input int b, input logic last);
        for (int k = 0; k < 4; k++)
            bus.s_ch_payload_tdata[8*k +: 8] = 8'((k << 4) | b);
        bus.s_ch_payload_tvalid = 4'hF;
        bus.s_ch_payload_tlast  = {4{last}};
    endtask

    task automatic tx_frame(input int g, input logic [15:0] sport);
        #1;
        check("tx_grant", bus.s_ch_hdr_ready, 64'(1 << g));
        step();
        check("tx_hdr_valid", bus.m_udp_hdr_valid, 1);
        check("tx_src_port", bus.m_udp_source_port, sport);
        check("tx_dst_port", bus.m_udp_dest_port, 64'(9000 + g));
        check("tx_dst_ip", bus.m_udp_ip_dest_ip, 64'(32'hC0A8_0000 + g));
        check("tx_length", bus.m_udp_length, 64'(20 + g));
        bus.m_udp_hdr_ready = 1'b1;
        step();
        bus.m_udp_hdr_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tx_drive(b, b == 2);
            #1;
            check("tx_data", bus.m_udp_payload_axis_tdata, 64'((g << 4) | b));
            check("tx_pay_ready", bus.s_ch_payload_tready, 64'(1 << g));
            check("tx_tlast", bus.m_udp_payload_axis_tlast, (b == 2));
            step();
        end
        bus.s_ch_payload_tvalid = 4'h0;
        bus.s_ch_payload_tlast  = 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        rst_n      = 1'b0;
        port_table = {16'd0, 16'd80, 16'd1234, 16'd7};
        bus.s_udp_hdr_valid           = 1'b0;
        bus.s_udp_ip_source_ip        = '0;
        bus.s_udp_source_port         = '0;
        bus.s_udp_dest_port           = '0;
        bus.s_udp_length              = '0;
        bus.s_udp_payload_axis_tdata  = '0;
        bus.s_udp_payload_axis_tvalid = 1'b0;
        bus.s_udp_payload_axis_tlast  = 1'b0;
        bus.s_udp_payload_axis_tuser  = 1'b0;
        bus.m_ch_hdr_ready            = '0;
        bus.m_ch_payload_tready       = 4'hF;
        bus.s_ch_hdr_valid            = '0;
        bus.s_ch_payload_tdata        = '0;
        bus.s_ch_payload_tvalid       = '0;
        bus.s_ch_payload_tlast        = '0;
        bus.s_ch_payload_tuser        = '0;
        bus.m_udp_hdr_ready           = 1'b0;
        bus.m_udp_payload_axis_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.s_ch_ip_dest_ip[32*k +: 32] = 32'hC0A8_0000 + 32'(k);
            bus.s_ch_dest_port[16*k +: 16]  = 16'(9000 + k);
            bus.s_ch_length[16*k +: 16]     = 16'(20 + k);
        end

        // reset state
        step();
        check("rst_hdr_ready", bus.s_udp_hdr_ready, 0);
        check("rst_m_udp_valid", bus.m_udp_hdr_valid, 0);
        check("rst_ch_hdr_valid", bus.m_ch_hdr_valid, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_m_udp_src", bus.m_udp_source_port, 0);
        rst_n = 1'b1;
        step();

        // RX to ch1, 10 bytes
        rx_hdr(16'd1234);
        rx_deliver(4'b0010, 16'd1234);
        rx_pay(10, 4'b0010, 8'h10);
        #1;
        check("rx_back_idle", bus.s_udp_hdr_ready, 1);

        // unmatched port dropped
        rx_hdr(16'd5555);
        check("drop_no_hdr", bus.m_ch_hdr_valid, 0);
        rx_pay(64, 4'b0000, 8'h00);
        check("drop_count_1", drop_count, 1);

        // duplicate port -> lowest channel
        port_table = {16'd0, 16'd80, 16'd1234, 16'd80};
        rx_hdr(16'd80);
        rx_deliver(4'b0001, 16'd80);
        rx_pay(4, 4'b0001, 8'h40);

        // dest 0 never matches a disabled channel
        port_table = {16'd0, 16'd80, 16'd1234, 16'd0};
        rx_hdr(16'd0);
        check("drop0_no_hdr", bus.m_ch_hdr_valid, 0);
        rx_pay(2, 4'b0000, 8'h00);
        check("drop_count_2", drop_count, 2);

        // saturation
        for (int f = 0; f < 13; f++) begin
            rx_hdr(16'd5555);
            rx_pay(1, 4'b0000, 8'h00);
        end
        check("drop_count_sat", drop_count, 4'hF);
        for (int f = 0; f < 3; f++) begin
            rx_hdr(16'd5555);
            rx_pay(1, 4'b0000, 8'h00);
        end
        check("drop_count_hold", drop_count, 4'hF);

        // TX round robin: 0,2,3,0
        port_table = {16'd0, 16'd80, 16'd1234, 16'd7};
        bus.s_ch_hdr_valid = 4'b1101;
        tx_frame(0, 16'd7);
        tx_frame(2, 16'd80);
        bus.s_ch_hdr_valid[2] = 1'b0;
        tx_frame(3, 16'd0);
        bus.s_ch_hdr_valid[3] = 1'b0;
        tx_frame(0, 16'd7);
        bus.s_ch_hdr_valid = 4'b0000;

        // TX backpressure on ch1, ch0 request must wait
        bus.s_ch_hdr_valid = 4'b0010;
        #1;
        check("bp_grant", bus.s_ch_hdr_ready, 4'b0010);
        step();
        bus.s_ch_hdr_valid = 4'b0000;
        check("bp_src_port", bus.m_udp_source_port, 1234);
        bus.m_udp_hdr_ready = 1'b1;
        step();
        bus.m_udp_hdr_ready = 1'b0;
        bus.s_ch_hdr_valid  = 4'b0001;
        idx = 0;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            bus.m_udp_payload_axis_tready = ~c[0];
            bus.s_ch_payload_tvalid       = 4'b0010;
            bus.s_ch_payload_tdata[15:8]  = 8'hA0 + 8'(idx);
            bus.s_ch_payload_tlast        = {2'b00, idx == 5, 1'b0};
            #1;
            check("bp_data", bus.m_udp_payload_axis_tdata, 8'hA0 + 8'(idx));
            check("bp_pay_ready", bus.s_ch_payload_tready,
                  bus.m_udp_payload_axis_tready ? 4'b0010 : 4'b0000);
            check("bp_no_regrant", bus.s_ch_hdr_ready, 0);
            step();
            if (bus.m_udp_payload_axis_tready) idx++;
        end
        check("bp_beats_done", idx, 6);
        bus.s_ch_payload_tvalid       = 4'h0;
        bus.s_ch_payload_tlast        = 4'h0;
        bus.m_udp_payload_axis_tready = 1'b1;

        // ch0 granted next, held in TX HDR; RX mid-frame on ch0
        #1;
        check("ch0_grant", bus.s_ch_hdr_ready, 4'b0001);
        step();
        bus.s_ch_hdr_valid = 4'b0000;
        check("ch0_hdr_valid", bus.m_udp_hdr_valid, 1);
        check("ch0_src_port", bus.m_udp_source_port, 7);
        rx_hdr(16'd7);
        rx_deliver(4'b0001, 16'd7);
        bus.s_udp_payload_axis_tdata  = 8'h55;
        bus.s_udp_payload_axis_tvalid = 1'b1;
        #1;
        check("mid_rx_valid", bus.m_ch_payload_tvalid, 4'b0001);
        rst_n = 1'b0;
        step();
        check("rst_mid_ch_valid", bus.m_ch_payload_tvalid, 0);
        check("rst_mid_m_udp", bus.m_udp_hdr_valid, 0);
        check("rst_mid_s_ready", bus.s_udp_payload_axis_tready, 0);
        check("rst_mid_hdr_rdy", bus.s_udp_hdr_ready, 0);
        check("rst_mid_drop", drop_count, 0);
        bus.s_udp_payload_axis_tvalid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // post-reset: rr back at 0, RX routes to ch2
        bus.s_ch_hdr_valid = 4'b0110;
        #1;
        check("post_rst_grant", bus.s_ch_hdr_ready, 4'b0010);
        bus.s_ch_hdr_valid = 4'b0000;
        rx_hdr(16'd80);
        rx_deliver(4'b0100, 16'd80);
        rx_pay(3, 4'b0100, 8'h30);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
